// File: rtl/muldiv_issue.sv
// Issue/control stage for an iterative multiply/divide unit.
// Owns HI/LO, stalls the pipeline while the unit is busy, and aborts on flush or timeout.
module muldiv_issue #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        err_o,
    output logic        md_start_o,
    output logic        md_annul_o,
    output logic        md_signed_o,
    output logic [1:0]  md_sel_o,
    output logic [31:0] md_op1_o,
    output logic [31:0] md_op2_o,
    input  logic [63:0] md_result_i,
    input  logic        md_ready_i
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_ABORT = 2'd3;

    localparam logic [1:0] SEL_MUL = 2'b01;
    localparam logic [1:0] SEL_DIV = 2'b10;

    // Counter is wide enough to hold TIMEOUT itself, the value it reaches on the abort edge.
    localparam int              CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_busy_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             r_err;
    logic             r_start;
    logic             r_annul;
    logic             r_signed;
    logic [1:0]       r_sel;
    logic [31:0]      r_op1;
    logic [31:0]      r_op2;

    logic w_idle;
    logic w_busy;
    logic w_req;
    logic w_is_mul;
    logic w_is_div;
    logic w_is_signed;
    logic w_start;
    logic w_mthi;
    logic w_mtlo;
    logic w_timeout;
    logic w_busy_flush;
    logic w_busy_done;
    logic w_busy_tmo;

    // Instruction decode and qualification
    assign w_idle      = (r_state == S_IDLE);
    assign w_busy      = (r_state == S_BUSY);
    assign w_req       = op_valid_i & ~flush_i;
    assign w_is_mul    = (op_i == OP_MULT) | (op_i == OP_MULTU);
    assign w_is_div    = (op_i == OP_DIV)  | (op_i == OP_DIVU);
    assign w_is_signed = (op_i == OP_MULT) | (op_i == OP_DIV);

    // A divide by zero never reaches the unit: no start, no stall, HI/LO untouched.
    assign w_start = w_idle & w_req & (w_is_mul | (w_is_div & (rt_i != 32'd0)));
    assign w_mthi  = w_idle & w_req & (op_i == OP_MTHI);
    assign w_mtlo  = w_idle & w_req & (op_i == OP_MTLO);

    assign w_cnt_inc = r_busy_cnt + CNT_W'(1);
    assign w_timeout = (w_cnt_inc == CNT_LIMIT);

    // Flush beats a same-cycle ready; ready beats the timeout.
    assign w_busy_flush = w_busy & flush_i;
    assign w_busy_done  = w_busy & ~flush_i & md_ready_i;
    assign w_busy_tmo   = w_busy & ~flush_i & ~md_ready_i & w_timeout;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_busy_flush || w_busy_tmo) begin
                    w_state_next = S_ABORT;
                end else if (w_busy_done) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            S_ABORT: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_start <= 1'b0;
            r_annul <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_start <= (w_state_next == S_BUSY);
            r_annul <= (w_state_next == S_ABORT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_cnt <= '0;
        end else if (w_start) begin
            r_busy_cnt <= '0;
        end else if (w_busy) begin
            r_busy_cnt <= w_cnt_inc;
        end
    end

    // Operand and mode latches stay frozen for the whole operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op1    <= 32'd0;
            r_op2    <= 32'd0;
            r_sel    <= 2'b00;
            r_signed <= 1'b0;
        end else if (w_start) begin
            r_op1    <= rs_i;
            r_op2    <= rt_i;
            r_sel    <= w_is_mul ? SEL_MUL : SEL_DIV;
            r_signed <= w_is_signed;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_busy_done) begin
            r_hi <= md_result_i[63:32];
            r_lo <= md_result_i[31:0];
        end else begin
            if (w_mthi) begin
                r_hi <= rs_i;
            end
            if (w_mtlo) begin
                r_lo <= rs_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_busy_tmo) begin
            r_err <= 1'b1;
        end
    end

    // Stall is gated by rst so it drops the instant reset is applied.
    assign stall_o     = ~rst & (w_start | w_busy);
    assign hi_o        = r_hi;
    assign lo_o        = r_lo;
    assign err_o       = r_err;
    assign md_start_o  = r_start;
    assign md_annul_o  = r_annul;
    assign md_signed_o = r_signed;
    assign md_sel_o    = r_sel;
    assign md_op1_o    = r_op1;
    assign md_op2_o    = r_op2;

endmodule

// File: doc/muldiv_issue.md
MULDIV_ISSUE -- requirements
Module: muldiv_issue

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 64: maximum BUSY cycles allowed before the block aborts the operation.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port op_valid_i, input, 1 bit: the EX stage holds a valid instruction.
REQ-005 The block SHALL have port op_i, input, 3 bits: operation code, encoded as follows.
- 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo.
- 111 is treated as none.
REQ-006 The block SHALL have ports rs_i and rt_i, input, 32 bits each: source operands.
REQ-007 The block SHALL have port flush_i, input, 1 bit: kill the EX instruction.
REQ-008 The block SHALL have port stall_o, output, 1 bit: freeze IF/ID/EX.
REQ-009 The block SHALL have ports hi_o and lo_o, output, 32 bits each: the architectural HI/LO registers.
REQ-010 The block SHALL have port err_o, output, 1 bit: sticky timeout flag.
REQ-011 The block SHALL have the following output ports to the iterative mul/div unit.
- md_start_o, 1 bit; md_annul_o, 1 bit; md_signed_o, 1 bit.
- md_sel_o, 2 bits: 01 multiply, 10 divide.
- md_op1_o and md_op2_o, 32 bits each.
REQ-012 The block SHALL have the following input ports from the iterative mul/div unit.
- md_result_i, 64 bits: multiply gives {hi, lo} of the product; divide gives {remainder, quotient}.
- md_ready_i, 1 bit.

Function
REQ-013 The block SHALL implement states IDLE, BUSY, DONE and ABORT in a registered FSM.
REQ-014 In IDLE, when op_valid_i=1 and flush_i=0 and op_i is mult, multu, or a div/divu with rt_i!=0, the block SHALL do the following at the next edge.
- Latch md_op1_o=rs_i and md_op2_o=rt_i.
- Set md_sel_o: 01 for mult/multu, 10 for div/divu.
- Set md_signed_o: 1 for mult/div, 0 for multu/divu.
- Set md_start_o=1 and enter BUSY.
REQ-015 The block SHALL drive stall_o combinationally as 1 when either condition holds, and 0 otherwise.
- In IDLE, for any qualifying start condition of REQ-014.
- In BUSY.
REQ-016 In BUSY, md_start_o, md_sel_o, md_signed_o and both operands SHALL be held constant.
REQ-017 In BUSY, when md_ready_i=1, the block SHALL do the following at that edge.
- Write hi_o=md_result_i[63:32] and lo_o=md_result_i[31:0].
- Clear md_start_o and enter DONE.
REQ-018 DONE SHALL last exactly one cycle with stall_o=0 and md_start_o=0, ignore op_valid_i (the completing instruction is still presented), and then return to IDLE.
REQ-019 div/divu with rt_i==0 SHALL NOT start the unit, SHALL NOT assert stall_o, and SHALL leave HI/LO unchanged.
REQ-020 mthi/mtlo with op_valid_i=1 and flush_i=0 in IDLE SHALL write rs_i into hi_o or lo_o (respectively) at the next edge, with no stall.
REQ-021 flush_i=1 in IDLE SHALL suppress any start or HI/LO write.
REQ-022 flush_i=1 in BUSY SHALL cause the following at the next edge, with flush taking priority over a simultaneous md_ready_i.
- md_start_o=0, md_annul_o=1, state ABORT.
- HI/LO are not written.
REQ-023 ABORT SHALL last one cycle, with md_annul_o=1 and stall_o=0 throughout, and then go to IDLE with md_annul_o=0.
REQ-024 A BUSY cycle counter SHALL clear on entering BUSY and increment each BUSY cycle.
REQ-025 When the BUSY counter reaches TIMEOUT without md_ready_i, the block SHALL do the following.
- Take the ABORT path and set err_o=1.
- err_o remains 1 until reset.
- HI/LO are unchanged.
REQ-026 md_annul_o SHALL be asserted only in ABORT.
REQ-027 md_start_o SHALL be asserted only in BUSY.

Reset
REQ-028 While rst=1 the block SHALL immediately force the following, independent of clk.
- State IDLE.
- hi_o=lo_o=0.
- md_start_o=md_annul_o=md_signed_o=0, md_sel_o=00, md_op1_o=md_op2_o=0.
- err_o=0 and BUSY counter=0.
- stall_o=0.
REQ-029 Reset asserted mid-BUSY SHALL abandon the operation without writing HI/LO.
REQ-030 After rst is released, the first rising edge SHALL evaluate IDLE rules.

Verification
REQ-031 mult, rs=0xFFFFFFFE, rt=0x00000003 -> md_sel=01 and md_signed=1; the unit returns 0xFFFFFFFF_FFFFFFFA -> HI=0xFFFFFFFF and LO=0xFFFFFFFA; stall_o is high from issue through the ready cycle and low in DONE.
REQ-032 divu, rs=100, rt=7 -> md_sel=10 and md_signed=0; the unit returns {2,14} -> HI=0x00000002 and LO=0x0000000E; no restart in DONE.
REQ-033 div, rs=5, rt=0 -> md_start_o stays 0, stall_o stays 0, HI/LO keep their prior values.
REQ-034 multu issued, then flush_i=1 on the 5th BUSY cycle together with md_ready_i=1 -> md_annul_o pulses exactly one cycle, HI/LO unchanged, IDLE 2 cycles after the flush.
REQ-035 TIMEOUT=8, md_ready_i held 0 -> ABORT after 8 BUSY cycles, err_o=1 sticky, stall_o=0 afterwards.
REQ-036 mthi rs=0x1234 then mtlo rs=0x5678 in IDLE -> hi_o=0x1234 and lo_o=0x5678 on successive edges; asynchronous rst mid-BUSY -> all outputs 0 without waiting for a clock edge.
